// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: scoreboard-based RAW/WAW hazard blocking, slot-0-only
// branch issue with a wait state until resolution, and a registered flush on taken.
module issue_scheduler #(
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s0_valid,
    input  logic            s1_valid,
    input  logic [4:0]      s0_rs,
    input  logic [4:0]      s0_rt,
    input  logic [4:0]      s1_rs,
    input  logic [4:0]      s1_rt,
    input  logic            s0_use_rs,
    input  logic            s0_use_rt,
    input  logic            s1_use_rs,
    input  logic            s1_use_rt,
    input  logic [4:0]      s0_rd,
    input  logic [4:0]      s1_rd,
    input  logic            s0_regwrite,
    input  logic            s1_regwrite,
    input  logic            s0_branch,
    input  logic            s1_branch,
    input  logic            wb0_en,
    input  logic            wb1_en,
    input  logic [4:0]      wb0_rd,
    input  logic [4:0]      wb1_rd,
    input  logic            br_resolve,
    input  logic            br_taken,
    output logic            issue0,
    output logic            issue1,
    output logic [1:0]      consume,
    output logic            flush,
    output logic [NREG-1:0] busy,
    output logic            br_wait
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            flush_d;
    logic [NREG-1:0] busy_d;
    logic            s0_haz, s1_haz, s0_waw_busy, s1_waw_busy;
    logic            pair_raw, pair_waw;
    logic            can_issue0, can_issue1;

    always_comb begin
        s0_haz      = (s0_use_rs && (s0_rs != 5'd0) && busy[s0_rs]) ||
                      (s0_use_rt && (s0_rt != 5'd0) && busy[s0_rt]);
        s1_haz      = (s1_use_rs && (s1_rs != 5'd0) && busy[s1_rs]) ||
                      (s1_use_rt && (s1_rt != 5'd0) && busy[s1_rt]);
        s0_waw_busy = s0_regwrite && busy[s0_rd];
        s1_waw_busy = s1_regwrite && busy[s1_rd];
        pair_raw    = s0_regwrite && (s0_rd != 5'd0) &&
                      ((s1_use_rs && (s1_rs == s0_rd)) ||
                       (s1_use_rt && (s1_rt == s0_rd)));
        pair_waw    = s0_regwrite && s1_regwrite && (s0_rd != 5'd0) && (s0_rd == s1_rd);
        can_issue0  = s0_valid && !s0_haz && !s0_waw_busy;
        can_issue1  = can_issue0 && s1_valid && !s0_branch && !s1_branch &&
                      !s1_haz && !pair_raw && !pair_waw && !s1_waw_busy;
    end

    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        issue0  = 1'b0;
        issue1  = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    issue0 = can_issue0;
                    issue1 = can_issue1;
                    if (can_issue0 && s0_branch)
                        state_d = BR_WAIT;
                end
                BR_WAIT: begin
                    if (br_resolve) begin
                        state_d = RUN;
                        flush_d = br_taken;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Clears first, then sets, so an issue to a register being written back keeps it busy.
    always_comb begin
        busy_d = busy;
        if (wb0_en) busy_d[wb0_rd] = 1'b0;
        if (wb1_en) busy_d[wb1_rd] = 1'b0;
        if (issue0 && s0_regwrite) busy_d[s0_rd] = 1'b1;
        if (issue1 && s1_regwrite) busy_d[s1_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            flush   <= 1'b0;
            busy    <= '0;
        end else begin
            state_q <= state_d;
            flush   <= flush_d;
            busy    <= busy_d;
        end
    end

    assign consume = {1'b0, issue0} + {1'b0, issue1};
    assign br_wait = (state_q == BR_WAIT);

endmodule
